// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Default sizes and the grant-index width function live here.
package bus_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam int NUM_REQ_DEF = 4;
   localparam int CNT_W_DEF   = 16;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Rotating-priority picker: rotate by ptr+1, find first set,
// rotate the winner back to an absolute master index.
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ID_W    = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic               o_any,
   output logic [ID_W-1:0]    o_idx,
   output logic [NUM_REQ-1:0] o_onehot
);

   logic [NUM_REQ-1:0] w_rot;
   logic               w_found;

   assign o_any = |i_req;

   // Lowest set bit of the rotated vector wins; map it back.
   always_comb begin
      w_rot    = '0;
      w_found  = 1'b0;
      o_idx    = '0;
      o_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_rot[i] = i_req[(i + int'(i_ptr) + 1) % NUM_REQ];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_rot[i] && !w_found) begin
            w_found = 1'b1;
            o_idx   = ID_W'((i + int'(i_ptr) + 1) % NUM_REQ);
            o_onehot[(i + int'(i_ptr) + 1) % NUM_REQ] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with burst lock, burst cap,
// abort detection and a saturating transaction counter.
module bus_rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int  NUM_REQ   = NUM_REQ_DEF,
   parameter int  MAX_BURST = 8,
   parameter int  CNT_W     = CNT_W_DEF,
   localparam int ID_W      = clog2_min1(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] req_last,
   input  logic               bus_ready,
   input  logic [CNT_W-1:0]   txn_target,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               gnt_valid,
   output logic               abort,
   output logic [CNT_W-1:0]   txn_count,
   output logic               done
);

   localparam int             BC_W      = $clog2(MAX_BURST) + 1;
   localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

   arb_state_t         r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [ID_W-1:0]    r_gnt_id;
   logic               r_gnt_valid;
   logic               r_abort;
   logic [ID_W-1:0]    r_ptr;
   logic [BC_W-1:0]    r_beat_cnt;
   logic [CNT_W-1:0]   r_txn_count;
   logic               r_done;

   logic               w_any;
   logic [ID_W-1:0]    w_idx;
   logic [NUM_REQ-1:0] w_onehot;
   logic               w_req_g;
   logic               w_fire;
   logic               w_cap;
   logic               w_complete;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_any    (w_any),
      .o_idx    (w_idx),
      .o_onehot (w_onehot)
   );

   assign w_req_g    = req[r_gnt_id];
   assign w_fire     = r_gnt_valid & w_req_g & bus_ready;
   assign w_cap      = (r_beat_cnt == LAST_BEAT);
   assign w_complete = (r_state == ARB_GRANT) & w_fire
                     & (req_last[r_gnt_id] | w_cap);

   // Grant FSM: pick in IDLE, hold until last beat, cap or abort.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ARB_IDLE;
         r_gnt       <= '0;
         r_gnt_id    <= '0;
         r_gnt_valid <= 1'b0;
         r_abort     <= 1'b0;
         r_ptr       <= ID_W'(NUM_REQ - 1);
         r_beat_cnt  <= '0;
      end else begin
         r_abort <= 1'b0;
         unique case (r_state)
            ARB_IDLE: begin
               if (w_any) begin
                  r_gnt       <= w_onehot;
                  r_gnt_id    <= w_idx;
                  r_gnt_valid <= 1'b1;
                  r_beat_cnt  <= '0;
                  r_state     <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (!w_req_g || w_complete) begin
                  r_abort     <= ~w_req_g;
                  r_gnt       <= '0;
                  r_gnt_valid <= 1'b0;
                  r_ptr       <= r_gnt_id;
                  r_beat_cnt  <= '0;
                  r_state     <= ARB_IDLE;
               end else if (w_fire) begin
                  r_beat_cnt  <= r_beat_cnt + 1'b1;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   // Completed transactions, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_txn_count <= '0;
      end else if (w_complete && (r_txn_count != '1)) begin
         r_txn_count <= r_txn_count + 1'b1;
      end
   end

   // Sticky done once the count has reached a nonzero target.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_done <= 1'b0;
      end else if ((txn_target != '0) && (r_txn_count >= txn_target)) begin
         r_done <= 1'b1;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_id    = r_gnt_id;
   assign gnt_valid = r_gnt_valid;
   assign abort     = r_abort;
   assign txn_count = r_txn_count;
   assign done      = r_done;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (NUM_REQ=4, MAX_BURST=8,
// CNT_W=4 so the saturation case is reachable).
module tb_bus_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] req_last;
   logic       bus_ready;
   logic [3:0] txn_target;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       abort;
   logic [3:0] txn_count;
   logic       done;

   int n_pass = 0;
   int n_chk  = 0;

   logic [3:0] exp_gnt [10];
   logic [3:0] exp_cnt [10];

   bus_rr_arbiter #(
      .NUM_REQ   (4),
      .MAX_BURST (8),
      .CNT_W     (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_last   (req_last),
      .bus_ready  (bus_ready),
      .txn_target (txn_target),
      .gnt        (gnt),
      .gnt_id     (gnt_id),
      .gnt_valid  (gnt_valid),
      .abort      (abort),
      .txn_count  (txn_count),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      exp_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
      exp_cnt = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2,
                  4'd3, 4'd3, 4'd4, 4'd4, 4'd5};

      // reset held with all masters requesting
      rst_n = 1'b0; req = 4'hF; req_last = 4'h0;
      bus_ready = 1'b1; txn_target = 4'd0;
      repeat (3) begin
         cyc();
         chk("rst_gnt", gnt, 0);
         chk("rst_valid", gnt_valid, 0);
         chk("rst_abort", abort, 0);
         chk("rst_cnt", txn_count, 0);
         chk("rst_done", done, 0);
      end

      // rotation 0,1,2,3,0 with single-beat bursts
      rst_n = 1'b1; req_last = 4'hF;
      for (int c = 0; c < 10; c++) begin
         cyc();
         chk("rot_gnt", gnt, exp_gnt[c]);
         chk("rot_valid", gnt_valid, |exp_gnt[c]);
         chk("rot_cnt", txn_count, exp_cnt[c]);
      end

      // burst cap: 12 beats from master 2 split 8 + 4
      req = 4'b0100; req_last = 4'h0;
      cyc();
      chk("cap_gnt", gnt, 4'b0100);
      chk("cap_id", gnt_id, 2);
      for (int b = 0; b < 7; b++) begin
         cyc();
         chk("cap_hold", gnt, 4'b0100);
         chk("cap_cnt", txn_count, 5);
      end
      cyc();
      chk("cap_rel", gnt, 0);
      chk("cap_cnt8", txn_count, 6);
      cyc();
      chk("cap_regnt", gnt, 4'b0100);
      repeat (3) cyc();
      chk("cap_hold2", gnt, 4'b0100);
      chk("cap_cnt2", txn_count, 6);
      req_last = 4'b0100;
      cyc();
      chk("cap_rel2", gnt, 0);
      chk("cap_cnt12", txn_count, 7);

      // stall then abort by master 1
      req = 4'b0010; req_last = 4'h0; bus_ready = 1'b0;
      cyc();
      chk("stl_gnt", gnt, 4'b0010);
      chk("stl_id", gnt_id, 1);
      for (int s = 0; s < 5; s++) begin
         cyc();
         chk("stl_hold", gnt, 4'b0010);
         chk("stl_abort0", abort, 0);
      end
      req = 4'b0100;
      cyc();
      chk("abt_pulse", abort, 1);
      chk("abt_gnt", gnt, 0);
      chk("abt_cnt", txn_count, 7);
      cyc();
      chk("abt_end", abort, 0);
      chk("abt_next", gnt, 4'b0100);
      bus_ready = 1'b1; req_last = 4'b0100;
      cyc();
      chk("abt_cnt2", txn_count, 8);
      req = 4'h0;

      // done with target 3
      rst_n = 1'b0;
      cyc();
      chk("rst2_cnt", txn_count, 0);
      rst_n = 1'b1; txn_target = 4'd3;
      req = 4'b0001; req_last = 4'hF;
      for (int t = 0; t < 6; t++) begin
         cyc();
         chk("don_low", done, 0);
      end
      chk("don_cnt3", txn_count, 3);
      cyc();
      chk("don_rise", done, 1);
      repeat (4) cyc();
      chk("don_stay", done, 1);
      chk("don_cnt5", txn_count, 5);
      txn_target = 4'd0;
      cyc();
      chk("don_sticky", done, 1);

      // target 0: never done; CNT_W=4 saturates at 15
      req = 4'h0; rst_n = 1'b0;
      cyc();
      chk("rst3_done", done, 0);
      chk("rst3_cnt", txn_count, 0);
      rst_n = 1'b1; req = 4'b0001;
      for (int t = 0; t < 40; t++) begin
         cyc();
         chk("zero_done", done, 0);
      end
      chk("sat_cnt", txn_count, 15);

      // target already below count sets done; then reset mid-burst
      req_last = 4'h0; txn_target = 4'd2;
      cyc();
      chk("low_tgt_done", done, 1);
      chk("mid_gnt", gnt, 4'b0001);
      repeat (2) cyc();
      chk("mid_hold", gnt, 4'b0001);
      chk("sat_hold", txn_count, 15);
      rst_n = 1'b0;
      cyc();
      chk("mrst_gnt", gnt, 0);
      chk("mrst_valid", gnt_valid, 0);
      chk("mrst_abort", abort, 0);
      chk("mrst_cnt", txn_count, 0);
      chk("mrst_done", done, 0);
      rst_n = 1'b1; req = 4'h0;
      cyc();
      chk("mrst_abort2", abort, 0);
      chk("mrst_gnt2", gnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
